adjacency_query_arbiter: RTL

- Shares the single query/reply port of adjacency_map between NUM_REQ requesters, for example topological_sort and a path-count walker.
- Each requester issues one node query, then consumes the full reply burst of that node's destination nodes.
- The grant is held from query handshake to the terminating reply beat, so replies are never interleaved.
- Priority is round-robin and rotates after each completed transaction.

---
 rtl/adjacency_query_arbiter_pkg.sv | 14 +
 rtl/aoc_graph_pkg.sv | 10 +
 rtl/adjacency_query_arbiter_if.sv | 39 +++
 rtl/adjacency_query_arbiter_chk.sv | 24 ++
 rtl/adjacency_query_arbiter_rr_pick.sv | 40 ++++
 rtl/adjacency_query_arbiter.sv | 146 ++++++++++++++
 6 files changed

// File: rtl/adjacency_query_arbiter_pkg.sv
// Arbiter-local types: FSM state encoding and grant-index sizing.
package adjacency_query_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_QUERY = 2'd1,
        S_REPLY = 2'd2
    } arb_state_t;

    function automatic int req_idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage : adjacency_query_arbiter_pkg

// File: rtl/aoc_graph_pkg.sv
// Graph-wide node sizing shared by adjacency_map, topological_sort,
// node_path_counter and the adjacency query arbiter.
package aoc_graph_pkg;

    localparam int MAX_NODES  = 1024;
    localparam int NODE_WIDTH = $clog2(MAX_NODES);

    typedef logic [NODE_WIDTH-1:0] node_t;

endpackage : aoc_graph_pkg

// File: rtl/adjacency_query_arbiter_if.sv
// Requester-side and adjacency_map-side handshake bundle of the arbiter.
// master is the arbiter's view, slave is the environment's view.
interface adjacency_query_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int NODE_WIDTH = aoc_graph_pkg::NODE_WIDTH
);
    logic [NUM_REQ-1:0]            req_query_valid;
    logic [NUM_REQ*NODE_WIDTH-1:0] req_query_data;
    logic [NUM_REQ-1:0]            req_query_ready;
    logic [NUM_REQ-1:0]            req_reply_valid;
    logic [NUM_REQ-1:0]            req_reply_ready;
    logic                          req_reply_last;
    logic [NODE_WIDTH-1:0]         req_reply_data;
    logic                          req_reply_no_edges_found;

    logic                          query_ready;
    logic                          query_valid;
    logic [NODE_WIDTH-1:0]         query_data;
    logic                          reply_ready;
    logic                          reply_valid;
    logic                          reply_last;
    logic [NODE_WIDTH-1:0]         reply_data;
    logic                          reply_no_edges_found;

    modport master (
        input  req_query_valid, req_query_data, req_reply_ready,
        input  query_ready, reply_valid, reply_last, reply_data, reply_no_edges_found,
        output req_query_ready, req_reply_valid, req_reply_last, req_reply_data,
        output req_reply_no_edges_found, query_valid, query_data, reply_ready
    );

    modport slave (
        output req_query_valid, req_query_data, req_reply_ready,
        output query_ready, reply_valid, reply_last, reply_data, reply_no_edges_found,
        input  req_query_ready, req_reply_valid, req_reply_last, req_reply_data,
        input  req_reply_no_edges_found, query_valid, query_data, reply_ready
    );

endinterface : adjacency_query_arbiter_if

// File: rtl/adjacency_query_arbiter_chk.sv
// Protocol checks for the arbiter: held queries must stay stable and at
// most one requester may see a reply beat.
module adjacency_query_arbiter_chk #(
    parameter int NUM_REQ    = 2,
    parameter int NODE_WIDTH = aoc_graph_pkg::NODE_WIDTH
) (
    input logic                  clk,
    input logic                  rst_n,
    input logic                  query_valid,
    input logic                  query_ready,
    input logic [NODE_WIDTH-1:0] query_data,
    input logic [NUM_REQ-1:0]    req_reply_valid
);

    property p_query_hold;
        @(posedge clk) disable iff (!rst_n)
            (query_valid && !query_ready) |=> (query_valid && $stable(query_data));
    endproperty

    a_query_hold: assert property (p_query_hold);

    a_reply_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_reply_valid));

endmodule : adjacency_query_arbiter_chk

// File: rtl/adjacency_query_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or
// above ptr, wrapping around at NUM_REQ.
module rr_pick
    import adjacency_query_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int REQ_IDX_WIDTH = req_idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]       req,
    input  logic [REQ_IDX_WIDTH-1:0] ptr,
    output logic                     hit,
    output logic [REQ_IDX_WIDTH-1:0] idx
);

    int off_s;
    int best_s;

    // Keep the request with the smallest distance from ptr.
    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        off_s  = 0;
        best_s = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i >= int'(ptr)) begin
                off_s = i - int'(ptr);
            end else begin
                off_s = i + NUM_REQ - int'(ptr);
            end
            if (req[i] && (off_s < best_s)) begin
                best_s = off_s;
                hit    = 1'b1;
                idx    = REQ_IDX_WIDTH'(i);
            end else begin
                best_s = best_s;
            end
        end
    end

endmodule : rr_pick

// File: rtl/adjacency_query_arbiter.sv
// Shares adjacency_map's query/reply port among NUM_REQ requesters; the
// grant is held from query handshake to the terminating reply beat.
module adjacency_query_arbiter
    import adjacency_query_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int NODE_WIDTH    = aoc_graph_pkg::NODE_WIDTH,
    parameter int REQ_IDX_WIDTH = req_idx_width(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    adjacency_query_arbiter_if.master  bus,
    output logic                       grant_valid,
    output logic [REQ_IDX_WIDTH-1:0]   grant_idx,
    output logic                       txn_done
);

    arb_state_t               state_r, state_s;
    logic [REQ_IDX_WIDTH-1:0] ptr_r, ptr_s;
    logic [REQ_IDX_WIDTH-1:0] grant_idx_r, grant_idx_s;
    logic                     grant_valid_r, grant_valid_s;
    logic                     txn_done_r, txn_done_s;

    logic                     pick_hit_s;
    logic [REQ_IDX_WIDTH-1:0] pick_idx_s;
    logic                     sel_qvalid_s;
    logic [NODE_WIDTH-1:0]    sel_qdata_s;
    logic                     sel_rready_s;
    logic                     in_query_s;
    logic                     in_reply_s;
    logic                     term_s;

    rr_pick #(
        .NUM_REQ       (NUM_REQ),
        .REQ_IDX_WIDTH (REQ_IDX_WIDTH)
    ) u_pick (
        .req (bus.req_query_valid),
        .ptr (ptr_r),
        .hit (pick_hit_s),
        .idx (pick_idx_s)
    );

    assign in_query_s = (state_r == S_QUERY);
    assign in_reply_s = (state_r == S_REPLY);

    // Select the owner's request fields and route map handshakes back to it only.
    always_comb begin
        sel_qvalid_s        = 1'b0;
        sel_qdata_s         = '0;
        sel_rready_s        = 1'b0;
        bus.req_query_ready = '0;
        bus.req_reply_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_r == REQ_IDX_WIDTH'(i)) begin
                sel_qvalid_s           = bus.req_query_valid[i];
                sel_qdata_s            = bus.req_query_data[i*NODE_WIDTH +: NODE_WIDTH];
                sel_rready_s           = bus.req_reply_ready[i];
                bus.req_query_ready[i] = in_query_s && bus.query_ready;
                bus.req_reply_valid[i] = in_reply_s && bus.reply_valid;
            end else begin
                sel_qvalid_s = sel_qvalid_s;
            end
        end
    end

    // Map-side query/backpressure and broadcast reply copies, gated by phase.
    always_comb begin
        bus.query_valid              = in_query_s && sel_qvalid_s;
        bus.query_data               = in_query_s ? sel_qdata_s : '0;
        bus.reply_ready              = in_reply_s && sel_rready_s;
        bus.req_reply_last           = in_reply_s && bus.reply_last;
        bus.req_reply_data           = in_reply_s ? bus.reply_data : '0;
        bus.req_reply_no_edges_found = in_reply_s && bus.reply_no_edges_found;
    end

    assign term_s = in_reply_s && bus.reply_valid && bus.reply_ready &&
                    (bus.reply_last || bus.reply_no_edges_found);

    // Next-state logic: arbitrate in IDLE, hold grant until the terminating beat.
    always_comb begin
        state_s       = state_r;
        ptr_s         = ptr_r;
        grant_idx_s   = grant_idx_r;
        grant_valid_s = grant_valid_r;
        txn_done_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (pick_hit_s) begin
                    state_s       = S_QUERY;
                    grant_idx_s   = pick_idx_s;
                    grant_valid_s = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_QUERY: begin
                if (bus.query_valid && bus.query_ready) begin
                    state_s = S_REPLY;
                end else begin
                    state_s = S_QUERY;
                end
            end
            S_REPLY: begin
                if (term_s) begin
                    state_s       = S_IDLE;
                    grant_valid_s = 1'b0;
                    txn_done_s    = 1'b1;
                    // Explicit wrap keeps non-power-of-2 NUM_REQ in range.
                    if (grant_idx_r == REQ_IDX_WIDTH'(NUM_REQ - 1)) begin
                        ptr_s = '0;
                    end else begin
                        ptr_s = grant_idx_r + REQ_IDX_WIDTH'(1);
                    end
                end else begin
                    state_s = S_REPLY;
                end
            end
            default: begin
                state_s       = S_IDLE;
                grant_valid_s = 1'b0;
            end
        endcase
    end

    // State and arbitration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            ptr_r         <= '0;
            grant_idx_r   <= '0;
            grant_valid_r <= 1'b0;
            txn_done_r    <= 1'b0;
        end else begin
            state_r       <= state_s;
            ptr_r         <= ptr_s;
            grant_idx_r   <= grant_idx_s;
            grant_valid_r <= grant_valid_s;
            txn_done_r    <= txn_done_s;
        end
    end

    assign grant_valid = grant_valid_r;
    assign grant_idx   = grant_idx_r;
    assign txn_done    = txn_done_r;

endmodule : adjacency_query_arbiter
